// File: rtl/button_debounce.sv
// button_debounce: synchronise a bouncing push-button and qualify each change over STABLE_CYCLES samples
module button_debounce #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W = 20,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, CHK_PRESS, HELD, CHK_RELEASE} state_t;
  state_t state, state_n;
  logic s1, s2, raw, last, level_n, press_n, release_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  assign raw = ACTIVE_LOW ? ~btn_in : btn_in;
  assign last = cnt == CNT_W'(STABLE_CYCLES - 1);
  assign busy = (state == CHK_PRESS) | (state == CHK_RELEASE);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    level_n = btn_level;
    press_n = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE: if (s2) begin
        state_n = CHK_PRESS;
        cnt_n = '0;
      end
      CHK_PRESS: if (!s2) begin
        state_n = IDLE;
        cnt_n = '0;
      end else if (last) begin
        state_n = HELD;
        level_n = 1'b1;
        press_n = 1'b1;
      end else cnt_n = cnt + CNT_W'(1);
      HELD: if (!s2) begin
        state_n = CHK_RELEASE;
        cnt_n = '0;
      end
      CHK_RELEASE: if (s2) begin
        state_n = HELD;
        cnt_n = '0;
      end else if (last) begin
        state_n = IDLE;
        level_n = 1'b0;
        release_n = 1'b1;
      end else cnt_n = cnt + CNT_W'(1);
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      btn_level <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      state <= state_n;
      cnt <= cnt_n;
      btn_level <= level_n;
      press_pulse <= press_n;
      release_pulse <= release_n;
    end
  end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench; expected strobes queued at stimulus time, checked by a strobe monitor
module tb_button_debounce;
  typedef struct { bit rel; int edge_n; } exp_t;
  logic clk = 0, reset = 1, btn_in = 1, btn2 = 1;
  logic btn_level, press_pulse, release_pulse, busy;
  logic lvl2, prs2, rls2, busy2;
  int checks = 0, errors = 0, edges = 0;
  exp_t q[$];

  button_debounce #(.STABLE_CYCLES(8), .CNT_W(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .busy(busy));
  button_debounce #(.STABLE_CYCLES(1), .CNT_W(1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .reset(reset), .btn_in(btn2), .btn_level(lvl2),
    .press_pulse(prs2), .release_pulse(rls2), .busy(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edges);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // strobe lands S+2 = 10 edges after the capture edge, which is the next edge
  task automatic expect_strobe(input bit rel);
    exp_t e;
    e.rel = rel;
    e.edge_n = edges + 11;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (press_pulse || release_pulse) begin
      chk("strobe_exclusive", int'(press_pulse & release_pulse), 0);
      if (q.size() == 0) chk("unexpected_strobe", int'(release_pulse), -1);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind", int'(release_pulse), int'(e.rel));
        chk("strobe_edge", edges, e.edge_n);
        chk("strobe_level", int'(btn_level), int'(!e.rel));
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      btn_in = i[0];
      tick();
      chk("reset_outputs", {btn_level, press_pulse, release_pulse, busy}, 0);
    end
    btn_in = 1;
    reset = 0;
    tick(4);
    chk("idle_level", int'(btn_level), 0);
    begin
      int base;
      base = edges;
      btn_in = 0;
      expect_strobe(0);
      for (int i = 0; i < 20; i++) begin
        int k;
        tick();
        k = edges - base - 1;
        chk("press_busy", int'(busy), int'(k >= 2 && k <= 9));
        chk("press_level", int'(btn_level), int'(k >= 10));
      end
    end
    for (int i = 0; i < 3; i++) begin
      btn_in = 1;
      tick();
      btn_in = 0;
      tick();
    end
    btn_in = 1;
    expect_strobe(1);
    tick(15);
    chk("released_level", int'(btn_level), 0);
    btn_in = 0;
    tick(5);
    btn_in = 1;
    tick();
    btn_in = 0;
    expect_strobe(0);
    tick(15);
    chk("bounced_press_level", int'(btn_level), 1);
    btn_in = 1;
    expect_strobe(1);
    tick(14);
    btn_in = 0;
    tick(7);
    chk("mid_qual_busy", int'(busy), 1);
    reset = 1;
    tick();
    chk("mid_reset_outputs", {btn_level, press_pulse, release_pulse, busy}, 0);
    reset = 0;
    expect_strobe(0);
    tick(14);
    chk("post_reset_level", int'(btn_level), 1);
    btn2 = 0;
    tick(3);
    chk("s1_e2_level", {lvl2, prs2}, 0);
    chk("s1_e2_busy", int'(busy2), 1);
    tick();
    chk("s1_e3_level_pulse", {lvl2, prs2}, 3);
    tick();
    chk("s1_e4_pulse", {lvl2, prs2}, 2);
    tick(3);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
